// File: rtl/even_parity_checker_serial.sv
// Serial even-parity receiver: rebuilds WIDTH-bit words sent MSB first plus a parity bit.
// Ports: clk, rst, E/D/V serial in, CLR_CNT; A/P/ERR/DONE frame result, ERR_CNT bad-frame count.
module even_parity_checker_serial #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic             D,
  input  logic             V,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] A,
  output logic             P,
  output logic             ERR,
  output logic             DONE,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RX_DATA,
    RX_PAR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sr;

  logic take;
  logic bad;
  logic frame_bad;

  // E gates V, so a parity bit seen while E is low never completes a frame.
  assign take      = E & V;
  assign bad       = ^{sr, D};
  assign frame_bad = take & (state == RX_PAR) & bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RX_DATA;
      idx     <= '0;
      sr      <= '0;
      A       <= '0;
      P       <= 1'b0;
      ERR     <= 1'b0;
      DONE    <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      DONE <= 1'b0;
      if (!E) begin
        state <= RX_DATA;
        idx   <= '0;
      end else if (V) begin
        unique case (state)
          RX_DATA: begin
            sr <= {sr[WIDTH-2:0], D};
            if (idx == LAST) begin
              state <= RX_PAR;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          RX_PAR: begin
            A     <= sr;
            P     <= D;
            ERR   <= bad;
            DONE  <= 1'b1;
            state <= RX_DATA;
            idx   <= '0;
          end
          default: begin
            state <= RX_DATA;
            idx   <= '0;
          end
        endcase
      end

      // Clear wins over increment, but a bad frame landing with the
      // clear still counts as the first error of the new run.
      if (CLR_CNT) begin
        ERR_CNT <= frame_bad ? CNT_W'(1) : '0;
      end else if (frame_bad && ERR_CNT != CNT_MAX) begin
        ERR_CNT <= ERR_CNT + 1'b1;
      end
    end
  end

endmodule

// File: doc/even_parity_checker_serial.md
# even_parity_checker_serial

Serial even-parity receiver/checker: the receive-side counterpart of the 3-bit even parity generator. It accepts a serial frame of WIDTH data bits (MSB first) followed by one parity bit, reassembles the data word, and flags frames whose total count of ones is odd. It also keeps a saturating count of bad frames. It sits at the far end of a link driven by the generator plus a serializer.

## Interface
- WIDTH, 3: data bits per frame (≥2)
- CNT_W, 8: error counter width (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- E  input  1  enable; low aborts any partial frame and ignores V
- D  input  1  serial data/parity bit
- V  input  1  D valid this cycle (sampled only when E=1)
- CLR_CNT  input  1  synchronous clear of ERR_CNT
- A  output  WIDTH  last received data word
- P  output  1  last received parity bit
- ERR  output  1  last frame failed even parity (^{A,P}==1)
- DONE  output  1  one-cycle pulse: A/P/ERR just updated
- ERR_CNT  output  CNT_W  saturating count of failed frames

## Operation
- Frame: WIDTH data bits, D[WIDTH-1] first, then parity bit. Even parity: a correct frame has an even number of ones across data+parity.
- FSM states:
  - RX_DATA (with bit index idx 0..WIDTH-1): on E&V, shift D into sr (sr <= {sr[WIDTH-2:0],D}). If idx==WIDTH-1, go to RX_PAR, else idx++.
  - RX_PAR: on E&V, A<=sr, P<=D, ERR<=^{sr,D}, DONE<=1, then return to RX_DATA with idx=0.
- V low (E=1): no state change, no shift. Gaps of any length between bits are legal.
- E low: state<=RX_DATA, idx<=0, sr contents don't-care. A, P, ERR, ERR_CNT hold. DONE=0. V ignored.
- ERR_CNT: increments on each completed frame with parity error, saturating at 2^CNT_W-1.
- CLR_CNT priority: clear beats increment. If CLR_CNT=1 in the same cycle a bad frame completes, ERR_CNT becomes 1, not 0.
- ERR is sticky only until the next completed frame. It is not cleared by CLR_CNT.

## Timing
- Reset (rst=1 at a clock edge): state=RX_DATA, idx=0, sr=0, A=0, P=0, ERR=0, DONE=0, ERR_CNT=0. Reset mid-frame discards the partial frame.
- All outputs are registered.
- Latency:
  - A/P/ERR/DONE/ERR_CNT update on the clock edge that samples the parity bit with E&V=1.
  - They are visible in the following cycle.
- Minimum frame time: WIDTH+1 cycles (V held high). Back-to-back frames are supported with no idle cycle.
- DONE is high for exactly one cycle per completed frame. With back-to-back frames, DONE pulses every WIDTH+1 cycles.
- E falling in the same cycle as the parity bit: the frame is aborted and no DONE is produced (E gates V).
- rst overrides E, V and CLR_CNT.

## Test plan
- Good frame, WIDTH=3: bits 0,1,1 then P=0 with V continuous → after 4th edge A=3'b011, P=0, ERR=0, DONE pulses once, ERR_CNT=0.
- Bad frame with gaps: bits 1,0,1 then P=1, V low for 2 cycles between each bit → A=3'b101, P=1, ERR=1, ERR_CNT=1. DONE appears only after the parity bit.
- Exhaustive sweep:
  - All 8 data values, each with correct P (^A), then each with inverted P.
  - Expect ERR=0 for the first 8 frames and ERR=1 for the next 8.
  - ERR_CNT=8 at the end.
  - 16 DONE pulses, frames sent back-to-back.
- Abort: send 2 data bits, drop E for 1 cycle, then send full frame 1,1,1,P=1 → A=3'b111, ERR=0. No DONE for the aborted frame. Outputs held during E low.
- Saturation and clear, CNT_W=2:
  - 4 bad frames → ERR_CNT saturates at 3.
  - CLR_CNT asserted in the same cycle a 5th bad frame completes → ERR_CNT=1.
  - CLR_CNT alone → ERR_CNT=0, ERR still 1.
- Reset mid-frame: 2 bits in, pulse rst → all outputs 0. A following full frame 0,0,1,P=1 gives A=3'b001, ERR=0, DONE pulses once.
